// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared types and constants for the register-file dump engine.
// Contents: FSM state encoding, bytes per register, byte counter type.
// Optional macro RF_DUMP_IDX_EN: adds a leading index byte per register (5 bytes instead of 4).
package rf_dump_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;
`ifdef RF_DUMP_IDX_EN
   localparam int BYTES_PER_REG = 5;
`else
   localparam int BYTES_PER_REG = 4;
`endif
   localparam int CNT_W = 3;
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t LAST_CNT = cnt_t'(BYTES_PER_REG - 1);
endpackage

// File: rtl/rf_dump_if.sv
// rf_dump_if: valid/ready byte stream carrying dump bytes to the UART/LED debug path.
// Signals: tx_data (8, byte), tx_valid (byte valid), tx_ready (sink accepts on valid && ready).
// Modports: master drives data/valid, slave drives ready.
interface rf_dump_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/rf_dump_byte_mux.sv
// rf_dump_byte_mux: combinational selection of the outgoing byte of a captured 32-bit word.
// Ports: i_shreg (captured word), i_cnt (byte position), i_idx (register index), o_byte (selected byte).
// Parameter MSB_FIRST: 1 sends bits 31:24 first, 0 sends bits 7:0 first.
// Optional macro RF_DUMP_IDX_EN: position 0 carries {3'b000, i_idx}, data occupies positions 1..4.
module rf_dump_byte_mux
   import rf_dump_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic [31:0] i_shreg,
   input  cnt_t        i_cnt,
   input  logic [4:0]  i_idx,
   output logic [7:0]  o_byte
);
   logic [1:0] w_dsel;
   logic [1:0] w_bsel;
`ifdef RF_DUMP_IDX_EN
   // data bytes sit one position later, behind the index byte
   assign w_dsel = 2'(i_cnt - 3'd1);
   assign o_byte = (i_cnt == '0) ? {3'b000, i_idx} : i_shreg[{w_bsel, 3'b000} +: 8];
`else
   assign w_dsel = 2'(i_cnt);
   assign o_byte = i_shreg[{w_bsel, 3'b000} +: 8];
`endif
   assign w_bsel = MSB_FIRST ? 2'd3 - w_dsel : w_dsel;
endmodule

// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: walks registers FIRST_REG..LAST_REG and streams each value out as bytes.
// Ports: clk, rst (async, active-high), i_start (dump request), o_busy, o_done (one-cycle pulse),
//        o_reg_sel / i_reg_data (register-file debug port), tx (rf_dump_if.master byte stream).
// Parameters: FIRST_REG, LAST_REG, MSB_FIRST.
// Optional macro RF_DUMP_IDX_EN: each register is preceded by an index byte.
module rf_dump_ctrl
   import rf_dump_pkg::*;
#(
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = 31,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_done,
   output logic [4:0]  o_reg_sel,
   input  logic [31:0] i_reg_data,
   rf_dump_if.master   tx
);
   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_reg_sel;
   cnt_t        r_cnt;
   logic [31:0] r_shreg;
   logic [7:0]  w_byte;
   logic        w_hs;
   logic        w_last_byte;
   logic        w_last_reg;
   assign w_hs        = tx.tx_valid && tx.tx_ready;
   assign w_last_byte = r_cnt == LAST_CNT;
   // LAST_REG is checked before incrementing, so reg_sel never wraps
   assign w_last_reg  = r_reg_sel == 5'(LAST_REG);
   rf_dump_byte_mux #(.MSB_FIRST(MSB_FIRST)) u_mux (
      .i_shreg (r_shreg),
      .i_cnt   (r_cnt),
      .i_idx   (r_reg_sel),
      .o_byte  (w_byte)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_reg_sel <= '0;
         r_cnt     <= '0;
         r_shreg   <= '0;
      end else begin
         r_state   <= w_next;
         r_reg_sel <= (r_state == IDLE && i_start) ? 5'(FIRST_REG) :
                      (r_state == FIN) ? 5'd0 :
                      (w_hs && w_last_byte && !w_last_reg) ? r_reg_sel + 5'd1 : r_reg_sel;
         r_cnt     <= (r_state == LOAD || (w_hs && w_last_byte)) ? '0 : w_hs ? r_cnt + 3'd1 : r_cnt;
         if (r_state == LOAD)
            r_shreg <= i_reg_data;
      end
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = i_start ? LOAD : IDLE;
         LOAD:    w_next = SEND;
         SEND:    w_next = (w_hs && w_last_byte) ? (w_last_reg ? FIN : LOAD) : SEND;
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   // all status outputs decode directly from state, so tx_valid never looks at tx_ready
   assign o_busy      = r_state == LOAD || r_state == SEND;
   assign o_done      = r_state == FIN;
   assign o_reg_sel   = r_reg_sel;
   assign tx.tx_valid = r_state == SEND;
   assign tx.tx_data  = (r_state == SEND) ? w_byte : 8'h00;
endmodule

// File: doc/rf_dump_ctrl.md
Name: rf_dump_ctrl

Overview:
Debug read-out engine for the register-file debug port (reg_sel / reg_data). On a start pulse it walks a register range and captures each 32-bit value. It serialises each value into bytes on a valid/ready byte stream that feeds the board UART/LED debug path. It is the reader side of the debug port and sits beside the CPU core at top level.

Parameters:
FIRST_REG, 1, first register index dumped (0..31)
LAST_REG, 31, last register index dumped (FIRST_REG..31)
MSB_FIRST, 1, 1: byte 3 (bits 31:24) sent first; 0: byte 0 first

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a dump
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last byte of LAST_REG is accepted
reg_sel  out  5  register index driven to the register-file debug port
reg_data  in  32  combinational read data for reg_sel; 0 when reg_sel==0
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data is valid
tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready at a clock edge

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, tx_valid=0, tx_data=0, reg_sel=0, byte counter=0, capture register=0.
- FSM states: IDLE, LOAD, SEND, FIN.
- IDLE:
  - start=1 sets reg_sel<=FIRST_REG and moves to LOAD; busy=1 from the next cycle.
  - start=0 holds reg_sel at 0.
- LOAD (one cycle):
  - shreg<=reg_data, which is the value of the register at that edge.
  - byte_cnt<=0; go to SEND.
- SEND:
  - tx_valid=1.
  - tx_data = byte selected by byte_cnt and MSB_FIRST.
  - On a handshake, byte_cnt increments.
  - On handshake of the last byte (cnt==3):
    - reg_sel==LAST_REG: go to FIN.
    - otherwise: reg_sel<=reg_sel+1 and go to LOAD.
- FIN (one cycle): done=1, busy=0, reg_sel<=0, then IDLE.
- Stream rules:
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without a handshake except on reset.
  - tx_valid is 0 in IDLE, LOAD and FIN.
  - tx_valid does not depend combinationally on tx_ready.
- Throughput: 1 idle cycle (LOAD) between registers. Minimum dump time = N*(4+1) + 2 cycles with tx_ready held at 1, where N = LAST_REG-FIRST_REG+1.
- start while busy (LOAD/SEND/FIN) is ignored; there is no queuing.
- Coherence: values are sampled per register at LOAD, so the dump is not an atomic snapshot. A concurrent CPU write to a later register is visible. The register file's write-forwarding does not apply to the debug port.
- FIRST_REG==LAST_REG gives a single-register dump. FIRST_REG==0 dumps x0 as 0x00000000.
- Reset mid-dump aborts immediately. No partial byte is presented after rst deasserts.
- reg_sel increment never wraps: LAST_REG is at most 31 and is checked before increment.

Optional Feature:
- Macro: RF_DUMP_IDX_EN.
- With the macro defined: each register's data bytes are preceded by an index byte {3'b000, reg_sel}. There are 5 bytes per register, byte_cnt runs 0..4, and the minimum time becomes N*6 + 2 cycles.
- Without the macro: 4 data bytes per register only.

Decomposition:
- Shared package: FSM state encoding (IDLE/LOAD/SEND/FIN, 2 bits), BYTES_PER_REG constant (4, or 5 under RF_DUMP_IDX_EN), byte counter width (3).
- Sub-module: rf_dump_byte_mux, a combinational byte select (shreg, byte_cnt, index, MSB_FIRST to tx_data). It is small and reused by the planned memory-dump block.
- Everything else stays in one module.

Test Plan:
- Reset, then idle with rst=0 for 5 cycles -> busy=0, tx_valid=0, reg_sel=0, done never pulses.
- Model RF with r1=0x11223344, r2=0xA5A5_0F0F; FIRST_REG=1, LAST_REG=2, MSB_FIRST=1, tx_ready=1, start pulse -> bytes 11,22,33,44,A5,A5,0F,0F; done pulses at cycle 12 after start; busy low after.
- Same setup with MSB_FIRST=0 -> bytes 44,33,22,11,0F,0F,A5,A5.
- tx_ready random (about 30% high) over full dump 1..31 with r[i]=i*0x01010101 -> 124 bytes received in order, each equal to its register index; tx_data stable whenever valid && !ready.
- start re-pulsed mid-dump, then rst asserted during byte 2 of r5 -> second start has no effect; after rst: tx_valid=0, reg_sel=0, busy=0 at once; new start dumps again from FIRST_REG.
- Build with RF_DUMP_IDX_EN, FIRST_REG=LAST_REG=7, r7=0xDEADBEEF -> bytes 07,DE,AD,BE,EF; done 1 cycle after the last handshake.
